// File: rtl/cond_unit_pkg.sv
// Shared controller definitions: condition-code encodings, flag bit
// positions within the {N,Z,C,V} vector, and the main FSM state type.
// No ports; imported by cond_check, cond_unit and the controller FSM.
package cond_unit_pkg;

    // Instr[31:28] condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Main controller FSM states; CondLatch is asserted only in DECODE
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECUTER = 4'd6,
        ST_EXECUTEI = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9
    } statetype;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluation: Cond x Flags -> CondEx.
// Ports: Cond (condition field), Flags ({N,Z,C,V}), CondEx (condition holds).
// The reserved NV encoding evaluates to 0 so it never enables a write.
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v, ge;

    assign n  = Flags[FLAG_N];
    assign z  = Flags[FLAG_Z];
    assign c  = Flags[FLAG_C];
    assign v  = Flags[FLAG_V];
    assign ge = (n == v);

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = ge;
            COND_LT: CondEx = ~ge;
            COND_GT: CondEx = ~z & ge;
            COND_LE: CondEx = z | ~ge;
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds the architectural {N,Z,C,V} flags and the
// latched condition result, and gates the PC/register/memory write requests.
// Ports: clk, reset (sync, active-low), Cond, ALUFlags, FlagW, CondLatch,
// PCS/NextPC/RegW/MemW in; PCWrite/RegWrite/MemWrite, CondExReg, Flags out.
module cond_unit
    import cond_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       CondLatch,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondExReg,
    output logic [3:0] Flags
);

    logic cond_ex;

    // Evaluated from the registered flags only; ALUFlags are never bypassed,
    // so a flag write becomes visible to the condition one cycle later.
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (Flags),
        .CondEx (cond_ex)
    );

    // Both updates read the pre-edge Flags/CondExReg, which gives the
    // latch-then-write ordering when CondLatch and FlagW coincide: the new
    // condition sees the old flags, and the flag write is gated by the
    // previously latched condition.
    always_ff @(posedge clk) begin
        if (!reset) begin
            Flags     <= 4'b0000;
            CondExReg <= 1'b0;
        end else begin
            if (CondLatch) begin
                CondExReg <= cond_ex;
            end
            if (FlagW[1] && CondExReg) begin
                Flags[FLAG_N] <= ALUFlags[FLAG_N];
                Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[0] && CondExReg) begin
                Flags[FLAG_C] <= ALUFlags[FLAG_C];
                Flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    // NextPC is the unconditional fetch increment and bypasses the gate.
    assign PCWrite  = (PCS & CondExReg) | NextPC;
    assign RegWrite = RegW & CondExReg;
    assign MemWrite = MemW & CondExReg;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed scenarios followed by random stimulus,
// compared against a behavioural model of the flag/condition rules.
// Inputs change at negedge; outputs are sampled 1 time unit later or 1 after posedge.
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       CondLatch;
    logic       PCS, NextPC, RegW, MemW;
    logic       PCWrite, RegWrite, MemWrite, CondExReg;
    logic [3:0] Flags;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit [3:0] m_flags;
    bit       m_cer;
    bit       m_known = 1'b0;

    always #5 clk = ~clk;

    cond_unit dut (
        .clk       (clk),
        .reset     (reset),
        .Cond      (Cond),
        .ALUFlags  (ALUFlags),
        .FlagW     (FlagW),
        .CondLatch (CondLatch),
        .PCS       (PCS),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .CondExReg (CondExReg),
        .Flags     (Flags)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Condition codes come in pairs: even code tests a predicate, odd code
    // its complement. 14 is always, 15 is never.
    function automatic bit eval_cond(input bit [3:0] code, input bit [3:0] f);
        bit n, z, c, v;
        bit pred;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        if (code == 4'd14) return 1'b1;
        if (code == 4'd15) return 1'b0;
        case (int'(code) / 2)
            0: pred = z;
            1: pred = c;
            2: pred = n;
            3: pred = v;
            4: pred = c && !z;
            5: pred = (n == v);
            default: pred = !z && (n == v);
        endcase
        return code[0] ? !pred : pred;
    endfunction

    // One clock cycle of stimulus with combinational and registered checks.
    task automatic cyc(input bit rst, input bit [3:0] cnd, input bit [3:0] alu,
                       input bit [1:0] fw, input bit lat, input bit pcs,
                       input bit npc, input bit rw, input bit mw);
        bit [3:0] nf;
        bit       ncer;
        @(negedge clk);
        reset = rst; Cond = cnd; ALUFlags = alu; FlagW = fw; CondLatch = lat;
        PCS = pcs; NextPC = npc; RegW = rw; MemW = mw;
        #1;
        if (m_known) begin
            check("pcwrite", {3'b0, PCWrite}, {3'b0, (pcs && m_cer) || npc});
            check("regwrite", {3'b0, RegWrite}, {3'b0, rw && m_cer});
            check("memwrite", {3'b0, MemWrite}, {3'b0, mw && m_cer});
        end else if (npc) begin
            check("pcwrite_nextpc", {3'b0, PCWrite}, 4'd1);
        end
        @(posedge clk);
        if (!rst) begin
            m_flags = 4'b0000;
            m_cer   = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            ncer = lat ? eval_cond(cnd, m_flags) : m_cer;
            nf   = m_flags;
            if (fw[1] && m_cer) nf[3:2] = alu[3:2];
            if (fw[0] && m_cer) nf[1:0] = alu[1:0];
            m_flags = nf;
            m_cer   = ncer;
        end
        #1;
        if (m_known) begin
            check("flags", Flags, m_flags);
            check("condexreg", {3'b0, CondExReg}, {3'b0, m_cer});
        end
    endtask

    initial begin
        reset = 1'b0; Cond = '0; ALUFlags = '0; FlagW = '0; CondLatch = 1'b0;
        PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;

        // reset held 2 cycles with flag writes requested: reset wins
        cyc(0, 4'b1110, 4'b1111, 2'b11, 1, 1, 0, 1, 1);
        cyc(0, 4'b1110, 4'b1111, 2'b11, 1, 1, 0, 1, 1);
        check("reset_flags", Flags, 4'b0000);
        check("reset_cer", {3'b0, CondExReg}, 4'd0);
        cyc(0, 4'b1110, 4'b0000, 2'b00, 0, 1, 1, 1, 1);  // NextPC ungated in reset
        // AL latch after reset
        cyc(1, 4'b1110, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
        check("al_latch", {3'b0, CondExReg}, 4'd1);

        // flag write with CondExReg=1
        cyc(1, 4'b0000, 4'b1001, 2'b11, 0, 0, 0, 0, 0);
        check("sub_flags", Flags, 4'b1001);
        // EQ with Z=0 -> CondExReg=0; then flag write is suppressed
        cyc(1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
        cyc(1, 4'b0000, 4'b0110, 2'b11, 0, 0, 0, 0, 0);
        check("flags_held", Flags, 4'b1001);

        // GT with 1001 -> 1
        cyc(1, 4'b1100, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
        check("gt_1001", {3'b0, CondExReg}, 4'd1);
        cyc(1, 4'b0000, 4'b0000, 2'b01, 0, 0, 0, 0, 0);  // flags -> 1000
        cyc(1, 4'b1100, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
        check("gt_1000", {3'b0, CondExReg}, 4'd0);
        // NV never enables writes
        cyc(1, 4'b1111, 4'b0000, 2'b00, 1, 0, 0, 1, 1);
        cyc(1, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 1, 1);

        // branch taken / not taken
        cyc(1, 4'b1110, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
        cyc(1, 4'b0000, 4'b0100, 2'b11, 0, 0, 0, 0, 0);  // flags -> 0100
        check("flags_0100", Flags, 4'b0100);
        cyc(1, 4'b0000, 4'b0000, 2'b00, 1, 1, 0, 0, 0);  // EQ latched = 1
        cyc(1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0);  // taken
        check("branch_taken", {3'b0, PCWrite}, 4'd1);
        cyc(1, 4'b0000, 4'b0000, 2'b11, 0, 0, 0, 0, 0);  // flags -> 0000
        cyc(1, 4'b0000, 4'b0000, 2'b00, 1, 1, 0, 0, 0);  // EQ latched = 0
        cyc(1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
        check("branch_not_taken", {3'b0, PCWrite}, 4'd0);
        cyc(1, 4'b0000, 4'b0000, 2'b00, 0, 1, 1, 0, 0);  // NextPC forces write

        // partial flag write: only N,Z
        cyc(1, 4'b1110, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
        cyc(1, 4'b0000, 4'b1111, 2'b10, 0, 0, 0, 0, 0);
        check("flagw_10", Flags, 4'b1100);

        // latch and flag write on the same edge from reset state
        cyc(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        cyc(1, 4'b0000, 4'b0100, 2'b11, 1, 0, 0, 0, 0);
        check("same_edge_cer", {3'b0, CondExReg}, 4'd0);
        check("same_edge_flags", Flags, 4'b0000);

        // reset mid-instruction discards a pending true condition
        cyc(1, 4'b1110, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
        cyc(0, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 1, 1);
        cyc(1, 4'b0000, 4'b1111, 2'b11, 0, 1, 0, 1, 1);
        check("post_reset_regwrite", {3'b0, RegWrite}, 4'd0);

        // random stimulus
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 24) != 0),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock; reset  in  1  synchronous reset, asserted when 0.
REQ-002 SHALL have input Cond  in  4  Instr[31:28] condition field of the current instruction.
REQ-003 SHALL have input ALUFlags  in  4  {N,Z,C,V} from the ALU, this cycle.
REQ-004 SHALL have input FlagW  in  2  flag-write request: bit1 updates N,Z; bit0 updates C,V.
REQ-005 SHALL have input CondLatch  in  1  strobe from the main FSM, high only in the DECODE state.
REQ-006 SHALL have inputs PCS, NextPC, RegW, MemW  in  1 each  ungated write requests from the FSM/decoder.
REQ-007 SHALL have outputs PCWrite, RegWrite, MemWrite  out  1 each  condition-gated write enables.
REQ-008 SHALL have outputs CondExReg  out  1  latched condition result, and Flags  out  4  architectural {N,Z,C,V} register.

Function
REQ-009 SHALL evaluate CondEx combinationally from Cond and the Flags register: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 reserved, evaluates to 0.
REQ-010 SHALL load CondExReg with CondEx on the rising edge where CondLatch=1, and hold it otherwise.
REQ-011 SHALL update Flags[3:2] from ALUFlags[3:2] on the edge where FlagW[1]=1 and CondExReg=1; Flags[1:0] likewise with FlagW[0].
REQ-012 SHALL make updated flags visible to CondEx one cycle after the write edge; it SHALL NOT bypass ALUFlags into the condition evaluation.
REQ-013 SHALL drive PCWrite = (PCS & CondExReg) | NextPC, combinationally with zero latency.
REQ-014 SHALL drive RegWrite = RegW & CondExReg and MemWrite = MemW & CondExReg, combinationally.
REQ-015 SHALL evaluate CondLatch against the Flags value held before any flag write on that same edge (latch-then-write ordering).
REQ-016 SHALL NOT let NextPC be suppressed by a failed condition, because the fetch increment is unconditional.

Reset
REQ-017 SHALL, on a rising edge with reset=0, set Flags=4'b0000 and CondExReg=0, overriding CondLatch and FlagW in that cycle.
REQ-018 SHALL hold PCWrite, RegWrite, and MemWrite at 0 during reset unless NextPC=1, since that term is ungated.
REQ-019 SHALL, when reset is asserted mid-instruction, discard the pending CondExReg so that no gated write occurs after reset is released until the next CondLatch.

Structure
REQ-020 SHALL take the condition-code encodings (EQ..AL, NV) and the flag bit indices (N=3, Z=2, C=1, V=0) from the shared controller package, alongside the FSM state typedef.
REQ-021 SHALL contain one natural sub-module, cond_check (a purely combinational Cond x Flags -> CondEx function); the flags and CondEx flops remain in cond_unit.
REQ-022 SHALL be instantiated inside controller, between the main FSM/decoder and the controller outputs.

Verification
REQ-023 SHALL cover: reset=0 for 2 cycles with FlagW=11 and ALUFlags=1111 -> Flags=0000 and CondExReg=0; then Cond=1110 with CondLatch -> CondExReg=1.
REQ-024 SHALL cover: Flags=0100, Cond=0000 (EQ), CondLatch, PCS=1 -> CondExReg=1 and PCWrite=1 (branch taken); with Flags=0000 -> PCWrite=0 (not taken), and PCWrite=1 whenever NextPC=1.
REQ-025 SHALL cover: SUB writing flags, with FlagW=11, ALUFlags=1001 and CondExReg=1 -> Flags=1001 next cycle; with CondExReg=0 -> Flags unchanged.
REQ-026 SHALL cover: FlagW=10 with ALUFlags=1111 starting from Flags=0000 -> Flags=1100 (C and V preserved).
REQ-027 SHALL cover: Cond=1100 (GT) with Flags=1001 -> CondEx=1; with Flags=1000 -> 0; and Cond=1111 -> RegWrite=0 and MemWrite=0 despite RegW=MemW=1.
REQ-028 SHALL cover: CondLatch and FlagW asserted on the same edge with Flags=0000, Cond=0000, ALUFlags=0100 -> CondExReg=0 (old flags used) and Flags unchanged.
